// File: rtl/tetris_pkg.sv
// rtl/tetris_pkg.sv - shared state encoding and board constants for the game controller
package tetris_pkg;

  localparam int ROWS_DEFAULT  = 11;
  localparam int ROW_W_DEFAULT = $clog2(ROWS_DEFAULT);
  localparam logic [ROW_W_DEFAULT-1:0] ROW_NONE = '1;

  typedef enum logic [2:0] {
    S_NEWBOARD = 3'd0,
    S_GEN      = 3'd1,
    S_MOVE     = 3'd2,
    S_LAND     = 3'd3,
    S_CLEAR    = 3'd4,
    S_PAUSE    = 3'd5,
    S_GAMEOVER = 3'd6
  } state_t;

  // Encoding 7 is unreachable; recover to a fresh board if it ever appears.
  localparam state_t STATE_ILLEGAL_NEXT = S_NEWBOARD;

endpackage

// File: rtl/game_ctrl_fsm_if.sv
// rtl/game_ctrl_fsm_if.sv - datapath handshake bundle between the game controller and its datapath
interface game_ctrl_fsm_if #(
  parameter int ROWS    = tetris_pkg::ROWS_DEFAULT,
  parameter int ROW_W   = $clog2(ROWS),
  parameter int LINES_W = 10,
  parameter int LEVEL_W = 4
);
  logic               start;
  logic               restart_game;
  logic               pause;
  logic               gen_done;
  logic               game_over;
  logic               touched;
  logic               land_done;
  logic [ROWS-1:0]    full_rows;
  logic               clear_done;
  logic [2:0]         state;
  logic               start_gen;
  logic               start_move;
  logic               start_land;
  logic               start_clear;
  logic [ROW_W-1:0]   clear_row;
  logic               drop_tick;
  logic [LINES_W-1:0] lines_total;
  logic [LEVEL_W-1:0] level;

  modport master (
    output start, restart_game, pause, gen_done, game_over, touched,
           land_done, full_rows, clear_done,
    input  state, start_gen, start_move, start_land, start_clear,
           clear_row, drop_tick, lines_total, level
  );

  modport slave (
    input  start, restart_game, pause, gen_done, game_over, touched,
           land_done, full_rows, clear_done,
    output state, start_gen, start_move, start_land, start_clear,
           clear_row, drop_tick, lines_total, level
  );
endinterface

// File: rtl/drop_timer.sv
// rtl/drop_timer.sv - level-dependent gravity period counter producing a one-cycle drop tick
module drop_timer #(
  parameter int LEVEL_W   = 4,
  parameter int DROP_BASE = 50,
  parameter int DROP_STEP = 5,
  parameter int DROP_MIN  = 5
) (
  input  logic               clka,
  input  logic               restart_n,
  input  logic               i_enable,
  input  logic               i_clear,
  input  logic [LEVEL_W-1:0] i_level,
  output logic               o_drop_tick
);
  localparam int P_MAX = (DROP_BASE > DROP_MIN) ? DROP_BASE : DROP_MIN;
  localparam int CNT_W = (P_MAX > 1) ? $clog2(P_MAX) : 1;

  logic [31:0]      w_step_total;
  logic [31:0]      w_period;
  logic [CNT_W-1:0] r_cnt;
  logic             r_tick;

  // Subtraction is only taken when it cannot underflow.
  always_comb begin
    w_step_total = 32'(i_level) * 32'(DROP_STEP);
    w_period     = 32'(DROP_MIN);
    if ((32'(DROP_BASE) > w_step_total) &&
        (32'(DROP_BASE) - w_step_total > 32'(DROP_MIN)))
      w_period = 32'(DROP_BASE) - w_step_total;
  end

  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (i_clear) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      if (i_enable) begin
        if (32'(r_cnt) >= w_period - 32'd1) begin
          r_cnt  <= '0;
          r_tick <= 1'b1;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign o_drop_tick = r_tick;
endmodule

// File: rtl/game_ctrl_fsm.sv
// rtl/game_ctrl_fsm.sv - game phase sequencer with multi-row clearing, line/level tracking and gravity
module game_ctrl_fsm
  import tetris_pkg::*;
#(
  parameter int ROWS            = ROWS_DEFAULT,
  parameter int ROW_W           = $clog2(ROWS),
  parameter int LINES_W         = 10,
  parameter int LEVEL_W         = 4,
  parameter int LEVEL_MAX       = 9,
  parameter int LINES_PER_LEVEL = 10,
  parameter int DROP_BASE       = 50,
  parameter int DROP_STEP       = 5,
  parameter int DROP_MIN        = 5
) (
  input logic            clka,
  input logic            restart_n,
  game_ctrl_fsm_if.slave bus
);
  localparam int SUB_W = $clog2(LINES_PER_LEVEL + 1);

  state_t             r_state;
  state_t             w_next;
  logic               w_pick;
  logic [ROWS-1:0]    w_src;
  logic               w_line;
  logic               w_wipe;
  logic               w_move_entry;
  logic [ROWS-1:0]    r_pending;
  logic [ROW_W-1:0]   r_clear_row;
  logic               r_start_gen;
  logic               r_start_move;
  logic               r_start_land;
  logic               r_start_clear;
  logic [LINES_W-1:0] r_lines;
  logic [SUB_W-1:0]   r_sub;
  logic [LEVEL_W-1:0] r_level;
  logic               w_drop_tick;

  // Lowest index first: clearing row r only shifts rows above it, so higher pending indices stay valid.
  function automatic logic [ROW_W-1:0] lowest_set(input logic [ROWS-1:0] mask);
    logic [ROW_W-1:0] idx;
    idx = ROW_W'(ROW_NONE);
    for (int i = ROWS - 1; i >= 0; i--)
      if (mask[i]) idx = ROW_W'(i);
    return idx;
  endfunction

  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) r_state <= S_NEWBOARD;
    else            r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_pick = 1'b0;
    w_src  = r_pending;
    case (r_state)
      S_NEWBOARD: if (bus.start) w_next = S_GEN;
      S_GEN:      if (bus.gen_done) w_next = bus.game_over ? S_GAMEOVER : S_MOVE;
      S_MOVE: begin
        if (bus.touched)    w_next = S_LAND;
        else if (bus.pause) w_next = S_PAUSE;
      end
      S_PAUSE:    if (bus.pause) w_next = S_MOVE;
      S_LAND: begin
        if (bus.land_done) begin
          if (bus.full_rows == '0) begin
            w_next = S_GEN;
          end else begin
            w_next = S_CLEAR;
            w_pick = 1'b1;
            w_src  = bus.full_rows;
          end
        end
      end
      S_CLEAR: begin
        if (bus.clear_done) begin
          if (r_pending == '0) w_next = S_GEN;
          else                 w_pick = 1'b1;
        end
      end
      S_GAMEOVER: if (bus.restart_game) w_next = S_NEWBOARD;
      default:    w_next = STATE_ILLEGAL_NEXT;
    endcase
  end

  assign w_line       = (r_state == S_CLEAR) && bus.clear_done;
  assign w_wipe       = (r_state == S_GAMEOVER) && bus.restart_game;
  assign w_move_entry = (r_state == S_GEN) && (w_next == S_MOVE);

  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) begin
      r_start_gen   <= 1'b0;
      r_start_move  <= 1'b0;
      r_start_land  <= 1'b0;
      r_start_clear <= 1'b0;
      r_clear_row   <= '0;
      r_pending     <= '0;
      r_lines       <= '0;
      r_sub         <= '0;
      r_level       <= '0;
    end else begin
      r_start_gen   <= (w_next == S_GEN)  && (r_state != S_GEN);
      r_start_move  <= (w_next == S_MOVE) && (r_state != S_MOVE);
      r_start_land  <= (w_next == S_LAND) && (r_state != S_LAND);
      r_start_clear <= w_pick;
      if (w_pick) begin
        r_clear_row <= lowest_set(w_src);
        r_pending   <= w_src & (w_src - ROWS'(1));
      end
      if (w_wipe) begin
        r_lines <= '0;
        r_sub   <= '0;
        r_level <= '0;
      end else if (w_line) begin
        if (r_lines != '1) r_lines <= r_lines + LINES_W'(1);
        if (32'(r_sub) == 32'(LINES_PER_LEVEL - 1)) begin
          r_sub <= '0;
          if (32'(r_level) < 32'(LEVEL_MAX)) r_level <= r_level + LEVEL_W'(1);
        end else begin
          r_sub <= r_sub + SUB_W'(1);
        end
      end
    end
  end

  drop_timer #(
    .LEVEL_W   (LEVEL_W),
    .DROP_BASE (DROP_BASE),
    .DROP_STEP (DROP_STEP),
    .DROP_MIN  (DROP_MIN)
  ) u_drop_timer (
    .clka        (clka),
    .restart_n   (restart_n),
    .i_enable    (r_state == S_MOVE),
    .i_clear     (w_move_entry),
    .i_level     (r_level),
    .o_drop_tick (w_drop_tick)
  );

  assign bus.state       = r_state;
  assign bus.start_gen   = r_start_gen;
  assign bus.start_move  = r_start_move;
  assign bus.start_land  = r_start_land;
  assign bus.start_clear = r_start_clear;
  assign bus.clear_row   = r_clear_row;
  assign bus.drop_tick   = w_drop_tick;
  assign bus.lines_total = r_lines;
  assign bus.level       = r_level;
endmodule

// File: tb/tb_game_ctrl_fsm.sv
// tb/tb_game_ctrl_fsm.sv - directed scoreboard bench for the game controller
module tb_game_ctrl_fsm;
  localparam logic [2:0] NB = 3'd0, GEN = 3'd1, MOVE = 3'd2, LAND = 3'd3,
                         CLR = 3'd4, GOV = 3'd6;
  localparam logic [3:0] P_NONE = 4'b0000, P_GEN = 4'b1000, P_MOVE = 4'b0100,
                         P_LAND = 4'b0010, P_CLR = 4'b0001;

  typedef struct {
    logic [2:0] st;
    logic [3:0] starts;
  } exp_t;

  logic clka;
  logic restart_n;
  int   checks;
  int   failures;
  int   lines_exp;
  int   level_exp;
  exp_t exp_q[$];
  int   clear_q[$];
  int   tick_q[$];

  game_ctrl_fsm_if bus();

  game_ctrl_fsm dut (
    .clka      (clka),
    .restart_n (restart_n),
    .bus       (bus)
  );

  initial begin
    clka = 1'b0;
    forever #5 clka = ~clka;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clka);
    #1;
  endtask

  task automatic step(input logic [2:0] st, input logic [3:0] starts);
    exp_t e;
    exp_q.push_back('{st, starts});
    cyc();
    e = exp_q.pop_front();
    chk("state", 32'(bus.state), 32'(e.st));
    chk("start_pulses", 32'({bus.start_gen, bus.start_move, bus.start_land, bus.start_clear}),
        32'(e.starts));
  endtask

  // Every start_clear pulse must match the next queued row index.
  always @(negedge clka) begin
    if (restart_n && bus.start_clear) begin
      if (clear_q.size() == 0) chk("start_clear_unexpected", 32'(bus.start_clear), 0);
      else                     chk("clear_row", 32'(bus.clear_row), 32'(clear_q.pop_front()));
    end
  end

  task automatic watch_ticks(input int n, input int p_on, input int p_off);
    for (int k = 1; k <= n; k++) begin
      bus.pause = ((k - 1) == p_on) || ((k - 1) == p_off);
      cyc();
      bus.pause = 1'b0;
      if (bus.drop_tick) begin
        if (tick_q.size() == 0) chk("drop_tick_extra", 32'(bus.drop_tick), 0);
        else                    chk("drop_tick_cycle", 32'(k), 32'(tick_q.pop_front()));
      end
    end
    chk("drop_tick_missing", 32'(tick_q.size()), 0);
  endtask

  task automatic land_rows(input logic [10:0] mask, input logic with_pause);
    int n;
    n = 0;
    bus.touched = 1'b1;
    bus.pause   = with_pause;
    step(LAND, P_LAND);
    bus.touched = 1'b0;
    bus.pause   = 1'b0;
    for (int r = 0; r < 11; r++) begin
      if (mask[r]) begin
        clear_q.push_back(r);
        n++;
      end
    end
    bus.land_done = 1'b1;
    bus.full_rows = mask;
    if (n == 0) step(GEN, P_GEN);
    else        step(CLR, P_CLR);
    bus.land_done = 1'b0;
    bus.full_rows = '0;
    for (int i = 0; i < n; i++) begin
      bus.clear_done = 1'b1;
      if (i == n - 1) step(GEN, P_GEN);
      else            step(CLR, P_CLR);
    end
    bus.clear_done = 1'b0;
    lines_exp += n;
    level_exp = (lines_exp / 10 > 9) ? 9 : lines_exp / 10;
    chk("lines_total", 32'(bus.lines_total), 32'(lines_exp));
    chk("level", 32'(bus.level), 32'(level_exp));
    bus.gen_done = 1'b1;
    step(MOVE, P_MOVE);
    bus.gen_done = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    lines_exp = 0;
    restart_n = 1'b0;
    bus.start = 1'b0;
    bus.restart_game = 1'b0;
    bus.pause = 1'b0;
    bus.gen_done = 1'b0;
    bus.game_over = 1'b0;
    bus.touched = 1'b0;
    bus.land_done = 1'b0;
    bus.full_rows = '0;
    bus.clear_done = 1'b0;
    #12;
    chk("rst_state", 32'(bus.state), 32'(NB));
    chk("rst_starts", 32'({bus.start_gen, bus.start_move, bus.start_land, bus.start_clear}), 0);
    chk("rst_clear_row", 32'(bus.clear_row), 0);
    chk("rst_lines", 32'(bus.lines_total), 0);
    chk("rst_level", 32'(bus.level), 0);
    chk("rst_drop_tick", 32'(bus.drop_tick), 0);
    @(negedge clka);
    restart_n = 1'b1;

    // Basic phase walk with ignored inputs
    step(NB, P_NONE);
    bus.start = 1'b1;     step(GEN, P_GEN);   bus.start = 1'b0;
    bus.pause = 1'b1;     step(GEN, P_NONE);  bus.pause = 1'b0;
    bus.gen_done = 1'b1;  step(MOVE, P_MOVE); bus.gen_done = 1'b0;
    bus.land_done = 1'b1; step(MOVE, P_NONE); bus.land_done = 1'b0;
    bus.touched = 1'b1;   step(LAND, P_LAND); bus.touched = 1'b0;
    bus.land_done = 1'b1; step(GEN, P_GEN);   bus.land_done = 1'b0;
    step(GEN, P_NONE);

    // Two rows, ascending order
    bus.gen_done = 1'b1;  step(MOVE, P_MOVE); bus.gen_done = 1'b0;
    bus.touched = 1'b1;   step(LAND, P_LAND); bus.touched = 1'b0;
    clear_q.push_back(2);
    clear_q.push_back(5);
    bus.land_done = 1'b1;
    bus.full_rows = 11'b000_0010_0100;
    step(CLR, P_CLR);
    bus.land_done = 1'b0;
    bus.full_rows = '0;
    step(CLR, P_NONE);
    chk("clear_row_held", 32'(bus.clear_row), 2);
    bus.clear_done = 1'b1; step(CLR, P_CLR); bus.clear_done = 1'b0;
    chk("lines_after_1", 32'(bus.lines_total), 1);
    step(CLR, P_NONE);
    bus.clear_done = 1'b1; step(GEN, P_GEN); bus.clear_done = 1'b0;
    chk("lines_after_2", 32'(bus.lines_total), 2);
    chk("clear_q_drained", 32'(clear_q.size()), 0);
    lines_exp = 2;

    // Gravity at level 0, then with a 20-cycle pause
    bus.gen_done = 1'b1; step(MOVE, P_MOVE); bus.gen_done = 1'b0;
    tick_q = '{50, 100};
    watch_ticks(120, -1, -1);
    lines_exp = 0;
    bus.touched = 1'b1;   step(LAND, P_LAND); bus.touched = 1'b0;
    bus.land_done = 1'b1; step(GEN, P_GEN);   bus.land_done = 1'b0;
    bus.gen_done = 1'b1;  step(MOVE, P_MOVE); bus.gen_done = 1'b0;
    tick_q = '{70};
    watch_ticks(75, 30, 50);
    chk("state_after_pause", 32'(bus.state), 32'(MOVE));

    // Climb to 100 lines; touched beats pause on the first landing
    lines_exp = 2;
    land_rows(11'h0FF, 1'b1);
    for (int i = 0; i < 9; i++) land_rows((i % 2 == 0) ? 11'h3FF : 11'h7FE, 1'b0);
    chk("lines_100", 32'(bus.lines_total), 100);
    chk("level_sat", 32'(bus.level), 9);
    tick_q = '{5, 10, 15};
    watch_ticks(16, -1, -1);

    // Game over and restart
    bus.touched = 1'b1;   step(LAND, P_LAND); bus.touched = 1'b0;
    bus.land_done = 1'b1; step(GEN, P_GEN);   bus.land_done = 1'b0;
    bus.gen_done = 1'b1;
    bus.game_over = 1'b1;
    step(GOV, P_NONE);
    bus.gen_done = 1'b0;
    bus.game_over = 1'b0;
    bus.start = 1'b1;        step(GOV, P_NONE); bus.start = 1'b0;
    chk("lines_kept_in_gameover", 32'(bus.lines_total), 100);
    bus.restart_game = 1'b1; step(NB, P_NONE);  bus.restart_game = 1'b0;
    chk("lines_wiped", 32'(bus.lines_total), 0);
    chk("level_wiped", 32'(bus.level), 0);

    // Asynchronous reset mid-CLEAR
    bus.start = 1'b1;     step(GEN, P_GEN);   bus.start = 1'b0;
    bus.gen_done = 1'b1;  step(MOVE, P_MOVE); bus.gen_done = 1'b0;
    bus.touched = 1'b1;   step(LAND, P_LAND); bus.touched = 1'b0;
    clear_q.push_back(2);
    clear_q.push_back(5);
    bus.land_done = 1'b1;
    bus.full_rows = 11'b000_0010_0100;
    step(CLR, P_CLR);
    bus.land_done = 1'b0;
    bus.full_rows = '0;
    bus.clear_done = 1'b1; step(CLR, P_CLR); bus.clear_done = 1'b0;
    step(CLR, P_NONE);
    chk("lines_before_reset", 32'(bus.lines_total), 1);
    #3;
    restart_n = 1'b0;
    #1;
    chk("async_state", 32'(bus.state), 32'(NB));
    chk("async_clear_row", 32'(bus.clear_row), 0);
    chk("async_lines", 32'(bus.lines_total), 0);
    chk("async_starts", 32'({bus.start_gen, bus.start_move, bus.start_land, bus.start_clear}), 0);
    #3;
    restart_n = 1'b1;
    cyc();
    chk("resume_state", 32'(bus.state), 32'(NB));
    bus.start = 1'b1; step(GEN, P_GEN); bus.start = 1'b0;
    chk("clear_q_final", 32'(clear_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
